alu_share_arbiter: RTL and testbench

Shares one combinational ALU (4-bit Operation, 32-bit SrcA/SrcB) between NUM_REQ requesters, e.g. execute-stage integer ops and a branch-compare unit.
- Grants round-robin with a valid/ready handshake per requester.
- Drives the ALU operands/opcode from the winner and registers the ALUResult into a single-entry response buffer.
- Sits between the issue logic and the shared ALU instance in the EX stage.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/alu_share_arbiter.sv | 122 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and arbiter state types.
// Imported by the arbiter and its round-robin grant logic.
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_AND   = 4'b0000;
    localparam alu_op_t ALU_XOR   = 4'b0001;
    localparam alu_op_t ALU_OR    = 4'b0010;
    localparam alu_op_t ALU_ADD   = 4'b0011;
    localparam alu_op_t ALU_SUB   = 4'b0100;
    localparam alu_op_t ALU_EQ    = 4'b0101;
    localparam alu_op_t ALU_NE    = 4'b0110;
    localparam alu_op_t ALU_LT    = 4'b0111;
    localparam alu_op_t ALU_GE    = 4'b1000;
    localparam alu_op_t ALU_SRL   = 4'b1001;
    localparam alu_op_t ALU_SLL   = 4'b1010;
    localparam alu_op_t ALU_SRA   = 4'b1011;
    localparam alu_op_t ALU_PASSB = 4'b1100;
    localparam alu_op_t ALU_TRUE  = 4'b1111;

    typedef enum logic {
        RSP_EMPTY,
        RSP_FULL
    } rsp_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above
// ptr, wrapping from NUM_REQ-1 back to 0.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               found
);

    logic [ID_W:0] w_sum;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        w_sum = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(NUM_REQ))
                w_sum = w_sum - (ID_W+1)'(NUM_REQ);
            if (!found && req[w_sum[ID_W-1:0]]) begin
                found = 1'b1;
                idx   = w_sum[ID_W-1:0];
            end
        end
        if (found)
            grant[idx] = 1'b1;
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU with a 1-entry result buffer.
// Define ALU_ARB_PERF_EN to add grant/stall performance counters.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter  int DATA_WIDTH    = 32,
    parameter  int OPCODE_LENGTH = 4,
    parameter  int NUM_REQ       = 2,
    localparam int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_srca,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_srcb,
    input  logic [NUM_REQ*OPCODE_LENGTH-1:0] req_op,
    output logic [DATA_WIDTH-1:0]          alu_srca,
    output logic [DATA_WIDTH-1:0]          alu_srcb,
    output logic [OPCODE_LENGTH-1:0]       alu_op,
    input  logic [DATA_WIDTH-1:0]          alu_result,
    output logic                           rsp_valid,
    output logic [ID_W-1:0]                rsp_id,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    input  logic                           rsp_ready
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0]          perf_grants,
    output logic [31:0]                    perf_stall
`endif
);

    rsp_state_e              r_state;
    rsp_state_e              w_state_nxt;
    logic [ID_W-1:0]         r_rr_ptr;
    logic [ID_W-1:0]         w_ptr_nxt;
    logic [ID_W-1:0]         r_rsp_id;
    logic [DATA_WIDTH-1:0]   r_rsp_data;
    logic [NUM_REQ-1:0]      w_grant;
    logic [ID_W-1:0]         w_idx;
    logic                    w_found;
    logic                    w_can_accept;
    logic                    w_gnt_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (r_rr_ptr),
        .grant (w_grant),
        .idx   (w_idx),
        .found (w_found)
    );

    // A full buffer can refill in the same cycle it drains.
    assign w_can_accept = !reset &&
                          (r_state == RSP_EMPTY || rsp_ready);
    assign w_gnt_any    = w_can_accept && w_found;
    assign req_ready    = w_gnt_any ? w_grant : '0;

    assign alu_srca = w_gnt_any ?
        req_srca[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign alu_srcb = w_gnt_any ?
        req_srcb[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign alu_op   = w_gnt_any ?
        req_op[int'(w_idx)*OPCODE_LENGTH +: OPCODE_LENGTH] : '0;

    assign w_ptr_nxt = (w_idx == ID_W'(NUM_REQ-1)) ? '0 : w_idx + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        if (w_gnt_any)
            w_state_nxt = RSP_FULL;
        else if (r_state == RSP_FULL && rsp_ready)
            w_state_nxt = RSP_EMPTY;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RSP_EMPTY;
            r_rr_ptr   <= '0;
            r_rsp_id   <= '0;
            r_rsp_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt_any) begin
                r_rsp_data <= alu_result;
                r_rsp_id   <= w_idx;
                r_rr_ptr   <= w_ptr_nxt;
            end
        end
    end

    assign rsp_valid = (r_state == RSP_FULL);
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;

`ifdef ALU_ARB_PERF_EN
    logic [NUM_REQ*32-1:0] r_perf_grants;
    logic [31:0]           r_perf_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_grants <= '0;
            r_perf_stall  <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_gnt_any && w_grant[i])
                    r_perf_grants[i*32 +: 32] <=
                        r_perf_grants[i*32 +: 32] + 32'd1;
            end
            if (|req_valid && !w_gnt_any)
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_grants = r_perf_grants;
    assign perf_stall  = r_perf_stall;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU model.
// Covers reset, single op, contention, backpressure, pointer hold.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int DW = 32;
    localparam int OL = 4;
    localparam int NR = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*DW-1:0] req_srca;
    logic [NR*DW-1:0] req_srcb;
    logic [NR*OL-1:0] req_op;
    logic [DW-1:0]   alu_srca;
    logic [DW-1:0]   alu_srcb;
    logic [OL-1:0]   alu_op;
    logic [DW-1:0]   alu_result;
    logic            rsp_valid;
    logic [0:0]      rsp_id;
    logic [DW-1:0]   rsp_data;
    logic            rsp_ready;
`ifdef ALU_ARB_PERF_EN
    logic [NR*32-1:0] perf_grants;
    logic [31:0]      perf_stall;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(
        .DATA_WIDTH    (DW),
        .OPCODE_LENGTH (OL),
        .NUM_REQ       (NR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_srca   (req_srca),
        .req_srcb   (req_srcb),
        .req_op     (req_op),
        .alu_srca   (alu_srca),
        .alu_srcb   (alu_srcb),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_ready  (rsp_ready)
`ifdef ALU_ARB_PERF_EN
        ,
        .perf_grants (perf_grants),
        .perf_stall  (perf_stall)
`endif
    );

    // Shared ALU stand-in
    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_AND:   alu_result = alu_srca & alu_srcb;
            ALU_XOR:   alu_result = alu_srca ^ alu_srcb;
            ALU_OR:    alu_result = alu_srca | alu_srcb;
            ALU_ADD:   alu_result = alu_srca + alu_srcb;
            ALU_SUB:   alu_result = alu_srca - alu_srcb;
            ALU_EQ:    alu_result = {31'b0, alu_srca == alu_srcb};
            ALU_NE:    alu_result = {31'b0, alu_srca != alu_srcb};
            ALU_LT:    alu_result = {31'b0, $signed(alu_srca) < $signed(alu_srcb)};
            ALU_GE:    alu_result = {31'b0, $signed(alu_srca) >= $signed(alu_srcb)};
            ALU_SRL:   alu_result = alu_srca >> alu_srcb[4:0];
            ALU_SLL:   alu_result = alu_srca << alu_srcb[4:0];
            ALU_SRA:   alu_result = $signed(alu_srca) >>> alu_srcb[4:0];
            ALU_PASSB: alu_result = alu_srcb;
            ALU_TRUE:  alu_result = 32'd1;
            default:   alu_result = '0;
        endcase
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        req_op[i*OL +: OL]   = op;
        req_srca[i*DW +: DW] = a;
        req_srcb[i*DW +: DW] = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_srca  = '0;
        req_srcb  = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
        set_req(0, ALU_ADD, 32'd5, 32'd7);
        req_valid = 2'b01;
        #2;
        check("rst_valid", rsp_valid, 0);
        check("rst_data",  rsp_data,  0);
        check("rst_id",    rsp_id,    0);
        check("rst_ready", req_ready, 0);
        tick();
        tick();
        reset     = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check("single_ready", req_ready, 2'b01);
        check("single_srca",  alu_srca,  5);
        check("single_srcb",  alu_srcb,  7);
        check("single_op",    alu_op,    ALU_ADD);
        tick();
        check("single_rvalid", rsp_valid, 1);
        check("single_rid",    rsp_id,    0);
        check("single_rdata",  rsp_data,  12);
        req_valid = '0;
        #1;
        check("idle_srca", alu_srca, 0);
        check("idle_op",   alu_op,   0);
        tick();
        check("drain_valid", rsp_valid, 0);
        check("drain_hold",  rsp_data,  12);

        // ptr is 1 here, so contention starts with requester 1
        set_req(0, ALU_ADD, 32'd1, 32'd1);
        set_req(1, ALU_XOR, 32'hF0, 32'hFF);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            int e;
            e = (k % 2 == 0) ? 1 : 0;
            #1;
            check("cont_ready", req_ready, 64'(1 << e));
            tick();
            check("cont_rid",   rsp_id, 64'(e));
            check("cont_rdata", rsp_data, (e == 1) ? 64'h0F : 64'd2);
            check("cont_rvalid", rsp_valid, 1);
        end

        req_valid = '0;
        tick();
        set_req(0, ALU_ADD, 32'd1, 32'd2);
        req_valid = 2'b01;
        #1;
        check("bp_fill_ready", req_ready, 2'b01);
        tick();
        check("bp_fill_data", rsp_data, 3);
        set_req(1, ALU_SUB, 32'd2, 32'd3);
        req_valid = 2'b10;
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("bp_ready", req_ready, 0);
            tick();
            check("bp_data",  rsp_data,  3);
            check("bp_valid", rsp_valid, 1);
            check("bp_id",    rsp_id,    0);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", req_ready, 2'b10);
        tick();
        check("bp_sub_data", rsp_data, 32'hFFFF_FFFF);
        check("bp_sub_id",   rsp_id,   1);

        // ptr now 0; idle cycles must not move it
        req_valid = '0;
        tick();
        tick();
        check("hold_empty", rsp_valid, 0);
        set_req(0, 4'b1101, 32'd9, 32'd9);
        req_valid = 2'b11;
        #1;
        check("hold_ready", req_ready, 2'b01);
        check("undef_op",   alu_op,    4'b1101);
        tick();
        check("hold_rid",   rsp_id,   0);
        check("undef_data", rsp_data, 0);

        // FULL with ptr=1; async reset between edges
        set_req(0, ALU_ADD, 32'd1, 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("arst_valid", rsp_valid, 0);
        check("arst_ready", req_ready, 0);
        check("arst_data",  rsp_data,  0);
        #2;
        reset = 1'b0;
        #1;
        check("post_rst_ready", req_ready, 2'b01);
        @(posedge clk);
        #1;
        check("post_rst_id",   rsp_id,   0);
        check("post_rst_data", rsp_data, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
